add_sat_stage: RTL



---
 rtl/add_sat_if.sv | 24 ++
 rtl/add_sat_stage.sv | 73 +++++++
 2 files changed

// File: rtl/add_sat_if.sv
// Handshake bundle between the adder, the saturating output stage and its consumer.
interface add_sat_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             a_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, sum, overflow, a_msb, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, sum, overflow, a_msb, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/add_sat_stage.sv
// Registered output stage for the ripple-carry adder: saturates signed overflow,
// buffers results in a 2-entry FIFO and counts accepted overflow events.
module add_sat_stage #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add_sat_if.slave             bus,
  input  logic                 clear_count,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  logic [WIDTH:0]     r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_occ;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic               w_push;
  logic               w_pop;
  logic [WIDTH:0]     w_entry;

  // Entry layout is {sat, data}; direction of saturation follows operand a's sign.
  always_comb begin
    w_entry = {1'b0, bus.sum};
    if (bus.overflow) begin
      if (bus.a_msb) w_entry = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      else           w_entry = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign bus.in_ready  = (r_occ != 2'd2);
  assign bus.out_valid = (r_occ != 2'd0);
  assign bus.out_data  = r_mem[r_rptr][WIDTH-1:0];
  assign bus.out_sat   = r_mem[r_rptr][WIDTH];
  assign ovf_count     = r_cnt;

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Clear takes priority, then the same-cycle overflow push is counted on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear_count) begin
      r_cnt <= (w_push && bus.overflow) ? CNT_WIDTH'(1) : '0;
    end else if (w_push && bus.overflow && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
